shm_port_master: RTL and testbench

SHM_PORT_MASTER -- requirements
Module: shm_port_master

---
 rtl/shm_port_master_if.sv | 43 ++++
 rtl/shm_port_master.sv | 141 ++++++++++++++
 tb/tb_shm_port_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shm_port_master_if.sv
// Bus bundle for shm_port_master: command, write-data, read-data, RAM port and statistics.
// The master modport is the port-master's view; slave is the view of the logic driving it.
interface shm_port_master_if #(
  parameter int unsigned LOCAL_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH       = 32
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [LOCAL_ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]                  cmd_len;

  logic                        wr_valid;
  logic                        wr_ready;
  logic [DATA_WIDTH-1:0]       wr_data;

  logic                        rd_valid;
  logic                        rd_ready;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_last;

  logic                        done;

  logic                        ram_we;
  logic [LOCAL_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]       ram_wdata;
  logic [DATA_WIDTH-1:0]       ram_rdata;

  logic [15:0]                 stat_wr_cnt;
  logic [15:0]                 stat_rd_cnt;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_we, ram_addr, ram_wdata,
    output stat_wr_cnt, stat_rd_cnt
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_we, ram_addr, ram_wdata,
    input  stat_wr_cnt, stat_rd_cnt
  );
endinterface

// File: rtl/shm_port_master.sv
// Burst master for one port of a dual-port RAM. Write bursts stream wr_data straight onto the
// RAM port; read bursts issue at most two outstanding reads into a 2-entry response buffer.
// Optional macro SHM_PM_STATS_EN enables saturating word counters on stat_wr_cnt/stat_rd_cnt.
module shm_port_master #(
  parameter int unsigned LOCAL_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH       = 32
) (
  input logic              clk,
  input logic              rst_n,
  shm_port_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  localparam logic [LOCAL_ADDR_WIDTH-1:0] AddrOne = 1;

  state_e                      state_q;
  logic [LOCAL_ADDR_WIDTH-1:0] addr_q;       // next word address (wraps naturally)
  logic [LOCAL_ADDR_WIDTH-1:0] last_addr_q;  // address shown while no burst drives the port
  logic [4:0]                  rem_q;        // words still to write / issue
  logic [4:0]                  dlv_q;        // read words still to hand over on rd_*
  logic                        inflight_q;   // read issued last cycle, data arrives now
  logic [DATA_WIDTH-1:0]       buf_q [2];
  logic                        wptr_q;
  logic                        rptr_q;
  logic [1:0]                  cnt_q;
  logic                        done_q;

  logic wr_hs;
  logic issue;
  logic pop;
  logic active;

  // Handshake and issue decisions
  assign wr_hs  = (state_q == StWrite) && bus.wr_valid;
  assign issue  = (state_q == StRead) && (rem_q != 5'd0) &&
                  ((cnt_q + {1'b0, inflight_q}) < 2'd2);
  assign pop    = (cnt_q != 2'd0) && bus.rd_ready;
  assign active = (state_q == StWrite) || (state_q == StRead);

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.wr_ready  = (state_q == StWrite);
  assign bus.ram_we    = wr_hs;
  assign bus.ram_addr  = active ? addr_q : last_addr_q;
  assign bus.ram_wdata = (state_q == StWrite) ? bus.wr_data : '0;
  assign bus.rd_valid  = (cnt_q != 2'd0);
  assign bus.rd_data   = buf_q[rptr_q];
  assign bus.rd_last   = (cnt_q != 2'd0) && (dlv_q == 5'd1);
  assign bus.done      = done_q;

  // Burst FSM, address/length counters and response buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      dlv_q       <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            rem_q   <= {1'b0, bus.cmd_len} + 5'd1;
            dlv_q   <= {1'b0, bus.cmd_len} + 5'd1;
            state_q <= bus.cmd_write ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (wr_hs) begin
            addr_q      <= addr_q + AddrOne;
            last_addr_q <= addr_q;
            rem_q       <= rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StRead: begin
          if (issue) begin
            addr_q      <= addr_q + AddrOne;
            last_addr_q <= addr_q;
            rem_q       <= rem_q - 5'd1;
            if (rem_q == 5'd1) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The final word can only be handed over here, after its issue.
          if (pop && (dlv_q == 5'd1)) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      inflight_q <= issue;
      if (inflight_q) begin
        buf_q[wptr_q] <= bus.ram_rdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
        dlv_q  <= dlv_q - 5'd1;
      end
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef SHM_PM_STATS_EN
  logic [15:0] stat_wr_q;
  logic [15:0] stat_rd_q;

  // Saturating counts of RAM writes and read-data handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (wr_hs && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
      if (pop && (stat_rd_q != 16'hFFFF)) stat_rd_q <= stat_rd_q + 16'd1;
    end
  end

  assign bus.stat_wr_cnt = stat_wr_q;
  assign bus.stat_rd_cnt = stat_rd_q;
`else
  assign bus.stat_wr_cnt = '0;
  assign bus.stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_shm_port_master.sv
// Scoreboard bench for shm_port_master: directed bursts followed by randomized traffic.
module tb_shm_port_master;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic last;} wr_exp_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shm_port_master_if #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  shm_port_master #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail = 0;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] wdata_buf [16];
  int mdl_wr = 0;
  int mdl_rd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string act, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%s required=%s", name, act, req);
  endtask

  // RAM attached to the port: synchronous read, one cycle latency
  logic [DW-1:0] ram_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
    bus_if.ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus_if.ram_we) ram_mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      bus_if.ram_rdata <= ram_mem[bus_if.ram_addr];
    end
  end

  // Monitor: pop and compare on every RAM write and read-data handshake; check done timing
  wr_exp_t mon_w;
  rd_exp_t mon_r;
  logic    mon_fin;
  logic    final_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      final_prev = 1'b0;
    end else begin
      mon_fin = 1'b0;
      if (bus_if.ram_we) begin
        if (wr_q.size() == 0) note_fail("ram_we", "unexpected write", "no write");
        else begin
          mon_w = wr_q.pop_front();
          chk("ram_addr", 64'(bus_if.ram_addr), 64'(mon_w.addr));
          chk("ram_wdata", 64'(bus_if.ram_wdata), 64'(mon_w.data));
          mon_fin = mon_w.last;
        end
      end
      if (bus_if.rd_valid && bus_if.rd_ready) begin
        if (rd_q.size() == 0) note_fail("rd_valid", "unexpected word", "no word");
        else begin
          mon_r = rd_q.pop_front();
          chk("rd_data", 64'(bus_if.rd_data), 64'(mon_r.data));
          chk("rd_last", 64'(bus_if.rd_last), 64'(mon_r.last));
          mon_fin = mon_fin | mon_r.last;
        end
      end
      if (bus_if.done || final_prev) chk("done_pulse", 64'(bus_if.done), 64'(final_prev));
      final_prev = mon_fin;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [3:0] l);
    int b;
    logic hs;
    b = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = l;
    do begin
      hs = bus_if.cmd_ready;
      step();
      b++;
    end while (!hs && b < 200);
    if (!hs) note_fail("cmd_accept", "timeout", "accepted");
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] l, input logic gappy);
    int i;
    int b;
    logic hs;
    logic [AW-1:0] ad;
    wr_exp_t e;
    for (int k = 0; k <= int'(l); k++) begin
      ad = a + AW'(k);
      model_mem[ad] = wdata_buf[k];
      e.addr = ad;
      e.data = wdata_buf[k];
      e.last = (k == int'(l));
      wr_q.push_back(e);
      mdl_wr++;
    end
    issue_cmd(1'b1, a, l);
    i = 0;
    b = 0;
    while (i <= int'(l) && b < 400) begin
      bus_if.wr_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus_if.wr_data  = wdata_buf[i];
      hs = bus_if.wr_valid & bus_if.wr_ready;
      step();
      b++;
      if (hs) i++;
    end
    bus_if.wr_valid = 1'b0;
    if (i <= int'(l)) note_fail("write_burst", "timeout", "all words accepted");
    if (!gappy) chk("write_back_to_back_cycles", 64'(b), 64'(int'(l) + 1));
    step();
  endtask

  // mode 0: rd_ready high; 1: random; 2: low for 5 cycles then high
  task automatic do_read(input logic [AW-1:0] a, input logic [3:0] l, input int mode,
                         output int lat);
    int got;
    int cyc;
    logic hs;
    logic rdy;
    logic [AW-1:0] ad;
    rd_exp_t e;
    for (int k = 0; k <= int'(l); k++) begin
      ad = a + AW'(k);
      e.data = model_mem[ad];
      e.last = (k == int'(l));
      rd_q.push_back(e);
      mdl_rd++;
    end
    issue_cmd(1'b0, a, l);
    got = 0;
    cyc = 0;
    lat = -1;
    while (got <= int'(l) && cyc < 400) begin
      if (mode == 2 && cyc == 5) chk("stall_issue_depth", 64'(bus_if.ram_addr), 64'(a + AW'(2)));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 5);
      bus_if.rd_ready = rdy;
      if (lat < 0 && bus_if.rd_valid) lat = cyc;
      hs = bus_if.rd_valid & rdy;
      step();
      cyc++;
      if (hs) got++;
    end
    bus_if.rd_ready = 1'b0;
    if (got <= int'(l)) note_fail("read_burst", "timeout", "all words delivered");
    step();
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'(1));
    chk("rst_wr_ready", 64'(bus_if.wr_ready), 64'(0));
    chk("rst_rd_valid", 64'(bus_if.rd_valid), 64'(0));
    chk("rst_rd_last", 64'(bus_if.rd_last), 64'(0));
    chk("rst_rd_data", 64'(bus_if.rd_data), 64'(0));
    chk("rst_done", 64'(bus_if.done), 64'(0));
    chk("rst_ram_we", 64'(bus_if.ram_we), 64'(0));
    chk("rst_ram_addr", 64'(bus_if.ram_addr), 64'(0));
    chk("rst_ram_wdata", 64'(bus_if.ram_wdata), 64'(0));
    chk("rst_stat_wr", 64'(bus_if.stat_wr_cnt), 64'(0));
    chk("rst_stat_rd", 64'(bus_if.stat_rd_cnt), 64'(0));
  endtask

  task automatic check_stats();
`ifdef SHM_PM_STATS_EN
    chk("stat_wr_cnt", 64'(bus_if.stat_wr_cnt), 64'((mdl_wr > 65535) ? 65535 : mdl_wr));
    chk("stat_rd_cnt", 64'(bus_if.stat_rd_cnt), 64'((mdl_rd > 65535) ? 65535 : mdl_rd));
`else
    chk("stat_wr_cnt", 64'(bus_if.stat_wr_cnt), 64'(0));
    chk("stat_rd_cnt", 64'(bus_if.stat_rd_cnt), 64'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int got;
    int b;
    logic hs;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.wr_data   = '0;
    bus_if.rd_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    step();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    // Directed write then read of the same four words
    wdata_buf[0] = 32'hDEADBEEF;
    wdata_buf[1] = 32'd1;
    wdata_buf[2] = 32'd2;
    wdata_buf[3] = 32'd3;
    do_write(10'h03F, 4'd3, 1'b0);
    chk("idle_ram_addr_after_write", 64'(bus_if.ram_addr), 64'(10'h042));
    do_read(10'h03F, 4'd3, 0, lat);
    chk("first_rd_valid_latency", 64'(lat), 64'(2));
    chk("idle_ram_addr_after_read", 64'(bus_if.ram_addr), 64'(10'h042));
    check_stats();

    // Stalled read of eight words
    for (int k = 0; k < 16; k++) wdata_buf[k] = $urandom;
    do_write(10'h100, 4'd7, 1'b1);
    do_read(10'h100, 4'd7, 2, lat);

    // Address wrap at the top of the RAM
    for (int k = 0; k < 16; k++) wdata_buf[k] = $urandom;
    do_write(10'h3FE, 4'd3, 1'b0);
    chk("idle_ram_addr_after_wrap", 64'(bus_if.ram_addr), 64'(10'h001));
    do_read(10'h3FE, 4'd3, 1, lat);

    // Reset in the middle of a read burst
    issue_cmd(1'b0, 10'h03F, 4'd3);
    for (int k = 0; k < 4; k++) rd_q.push_back('{data: model_mem[10'h03F + AW'(k)],
                                                  last: (k == 3)});
    got = 0;
    b = 0;
    bus_if.rd_ready = 1'b1;
    while (got < 1 && b < 50) begin
      hs = bus_if.rd_valid;
      step();
      b++;
      if (hs) got++;
    end
    if (got < 1) note_fail("reset_mid_read_setup", "timeout", "first beat");
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    wr_q.delete();
    rd_q.delete();
    mdl_wr = 0;
    mdl_rd = 0;
    bus_if.rd_ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_done_after_reset", 64'(bus_if.done), 64'(0));
    end
    for (int k = 0; k < 16; k++) wdata_buf[k] = $urandom;
    do_write(10'h010, 4'd3, 1'b0);
    do_read(10'h010, 4'd3, 0, lat);
    check_stats();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [3:0] l;
      a = AW'($urandom_range(0, 1023));
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) wdata_buf[k] = $urandom;
        do_write(a, l, 1'b1);
      end else begin
        do_read(a, l, 1, lat);
      end
    end

    step();
    step();
    chk("wr_queue_drained", 64'(wr_q.size()), 64'(0));
    chk("rd_queue_drained", 64'(rd_q.size()), 64'(0));
    check_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
